control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 start  input  1  begin execution from the current PC; honoured only in IDLE.
REQ-005 stop  input  1  request return to IDLE; honoured at instruction boundary only.
REQ-006 opcode  input  7  IR opcode field (IR data_in[6:0] registered), valid from EXEC onward.
REQ-007 pc_we  output  1  PC load enable (PC <= PC+1).
REQ-008 ir_we  output  1  IR load enable from instruction-memory dout.
REQ-009 rf_we  output  1  register-file write enable.
REQ-010 dmem_we  output  1  data-memory write enable (0 = read).
REQ-011 alu_b_sel  output  1  operand-B mux select: 0 = immediate C[31:20], 1 = register Rb.
REQ-012 wb_sel  output  1  write-back mux select: 0 = data-memory dout, 1 = ALU result.
REQ-013 alu_sub  output  1  ALU operation: 0 = add, 1 = subtract.
REQ-014 busy  output  1  high in every state except IDLE and HALT.
REQ-015 illegal  output  1  sticky flag, high in HALT.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 Opcodes: LOAD 0000001, STORE 0000010, ADD 0000011, SUB 0000100, ADDI 0000101, SUBI 0000110; all others illegal.
REQ-018 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; Moore outputs decoded from state plus opcode latched on EXEC entry.
REQ-019 IDLE: all enables 0; start=1 -> FETCH next cycle.
REQ-020 FETCH: all enables 0 (registered instruction-memory read in flight) -> DECODE.
REQ-021 DECODE: ir_we=1, pc_we=1 for exactly one cycle -> EXEC.
REQ-022 EXEC: latch opcode; illegal -> HALT; LOAD/STORE -> MEM; ADD/SUB/ADDI/SUBI -> WB.
REQ-023 EXEC/MEM/WB drive alu_b_sel=1 for ADD/SUB and 0 for LOAD/STORE/ADDI/SUBI; alu_sub=1 for SUB/SUBI only.
REQ-024 MEM: dmem_we=1 for STORE only; STORE completes from MEM; LOAD -> WB.
REQ-025 WB: rf_we=1 for one cycle; wb_sel=0 for LOAD, 1 for ALU ops.
REQ-026 Latency (FETCH to last state, inclusive): ALU ops 4 cycles, STORE 4, LOAD 5.
REQ-027 Instruction completion (last of WB for LOAD/ALU, MEM for STORE): retired increments by 1; then IDLE if stop=1, else FETCH.
REQ-028 stop asserted mid-instruction has no effect until completion; stop and start simultaneously in IDLE -> remain IDLE.
REQ-029 start while busy or in HALT is ignored.
REQ-030 retired wraps from 2^CNT_W-1 to 0 without side effects.
REQ-031 HALT: all enables 0, illegal=1, busy=0; exited only by reset.
REQ-032 At most one of rf_we, dmem_we, ir_we is high in any cycle.

Reset
REQ-033 rst_n=0 at posedge: state <= IDLE, latched opcode <= 0, illegal <= 0, retired <= 0.
REQ-034 Outputs during and after reset: pc_we, ir_we, rf_we, dmem_we, alu_b_sel, wb_sel, alu_sub, busy = 0.
REQ-035 Reset mid-instruction aborts it: no rf_we/dmem_we pulse after the reset edge; retired not incremented.

Configuration
REQ-036 Macro CU_INSTR_COUNT_EN: defined -> retired counter implemented per REQ-027/030/033.
REQ-037 CU_INSTR_COUNT_EN undefined -> no counter register; retired tied to 0; all other behaviour unchanged.

Verification
REQ-038 Reset, start=1 with opcode ADD -> states FETCH,DECODE,EXEC,WB; rf_we one cycle with wb_sel=1, alu_b_sel=1, alu_sub=0; retired=1.
REQ-039 Opcode LOAD -> 5-cycle sequence; MEM has dmem_we=0; WB has rf_we=1, wb_sel=0, alu_b_sel=0.
REQ-040 Opcode STORE -> dmem_we=1 in MEM for one cycle, rf_we never high; next state FETCH.
REQ-041 Opcode 1111111 -> HALT after EXEC, illegal=1, busy=0; start ignored; rst_n=0 clears illegal.
REQ-042 stop=1 raised during EXEC of SUBI -> WB completes (alu_sub=1, alu_b_sel=0), then IDLE; retired increments once.
REQ-043 rst_n=0 during MEM of STORE -> no dmem_we after the edge, state IDLE, retired=0; with CU_INSTR_COUNT_EN undefined, retired=0 throughout.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle sequencer for a small load/store datapath. Walks each
//   instruction through FETCH, DECODE, EXEC and then MEM and/or WB, and
//   drives the datapath enables and mux selects from the current state
//   together with the instruction opcode. An illegal opcode parks the unit
//   in HALT until reset.
//
//   Optional feature: define CU_INSTR_COUNT_EN to build the retired-
//   instruction counter. Without it, retired is tied to zero.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin execution (honoured only in IDLE)
//   stop       in   return to IDLE at the next instruction boundary
//   opcode     in   [6:0] opcode field from the instruction register
//   pc_we      out  PC increment enable
//   ir_we      out  instruction register load enable
//   rf_we      out  register-file write enable
//   dmem_we    out  data-memory write enable
//   alu_b_sel  out  operand B: 0 = immediate, 1 = register Rb
//   wb_sel     out  write-back: 0 = data memory, 1 = ALU result
//   alu_sub    out  ALU: 0 = add, 1 = subtract
//   busy       out  high outside IDLE and HALT
//   illegal    out  high while halted on an illegal opcode
//   retired    out  [CNT_W-1:0] completed-instruction count
module control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [6:0]       opcode,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             dmem_we,
  output logic             alu_b_sel,
  output logic             wb_sel,
  output logic             alu_sub,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000001;
  localparam logic [6:0] OP_STORE = 7'b0000010;
  localparam logic [6:0] OP_ADD   = 7'b0000011;
  localparam logic [6:0] OP_SUB   = 7'b0000100;
  localparam logic [6:0] OP_ADDI  = 7'b0000101;
  localparam logic [6:0] OP_SUBI  = 7'b0000110;

  state_t     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [6:0] opSel;
  logic       isRegOp;
  logic       isSubOp;
  logic       done;

  // State and latched opcode; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Capture the opcode while in EXEC so MEM/WB keep decoding the same
  // instruction even if the IR field changes afterwards.
  always_comb begin
    opcode_d = opcode_q;
    if (state_q == S_EXEC) opcode_d = opcode;
  end

  // In EXEC the live IR field is already valid; later states use the copy.
  assign opSel   = (state_q == S_EXEC) ? opcode : opcode_q;
  assign isRegOp = (opSel == OP_ADD) || (opSel == OP_SUB);
  assign isSubOp = (opSel == OP_SUB) || (opSel == OP_SUBI);

  // Next-state and Moore outputs.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 1'b0;
    alu_sub   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start together with stop is treated as "stay idle".
        if (start && !stop) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_b_sel = isRegOp;
        alu_sub   = isSubOp;
        case (opcode)
          OP_LOAD, OP_STORE:                state_d = S_MEM;
          OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: state_d = S_WB;
          default:                          state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        alu_b_sel = isRegOp;
        alu_sub   = isSubOp;
        if (opcode_q == OP_STORE) begin
          dmem_we = 1'b1;
          done    = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        wb_sel    = (opcode_q != OP_LOAD);
        alu_b_sel = isRegOp;
        alu_sub   = isSubOp;
        done      = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: the only point where stop is honoured.
    if (done) state_d = stop ? S_IDLE : S_FETCH;
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = (state_q == S_HALT);

`ifdef CU_INSTR_COUNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Counts completed instructions, wrapping naturally at full scale.
  always_comb begin
    retired_d = retired_q;
    if (done) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. Each scenario pushes one entry per clock
// cycle onto a scoreboard queue: the outputs expected in that cycle plus
// the inputs to drive for the following edge. The scenario then drains the
// queue, comparing the DUT outputs on each falling edge.
module tb_control_unit;

  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000001;
  localparam logic [6:0] OP_STORE = 7'b0000010;
  localparam logic [6:0] OP_ADD   = 7'b0000011;
  localparam logic [6:0] OP_SUB   = 7'b0000100;
  localparam logic [6:0] OP_ADDI  = 7'b0000101;
  localparam logic [6:0] OP_SUBI  = 7'b0000110;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Control bit order: pc_we ir_we rf_we dmem_we alu_b_sel wb_sel alu_sub busy illegal
  localparam logic [8:0] V_IDLE      = 9'b000000000;
  localparam logic [8:0] V_FETCH     = 9'b000000010;
  localparam logic [8:0] V_DECODE    = 9'b110000010;
  localparam logic [8:0] V_EXEC_ADD  = 9'b000010010;
  localparam logic [8:0] V_EXEC_SUB  = 9'b000010110;
  localparam logic [8:0] V_EXEC_ADDI = 9'b000000010;
  localparam logic [8:0] V_EXEC_SUBI = 9'b000000110;
  localparam logic [8:0] V_EXEC_MEM  = 9'b000000010;
  localparam logic [8:0] V_EXEC_BAD  = 9'b000000010;
  localparam logic [8:0] V_MEM_LOAD  = 9'b000000010;
  localparam logic [8:0] V_MEM_STORE = 9'b000100010;
  localparam logic [8:0] V_WB_ADD    = 9'b001011010;
  localparam logic [8:0] V_WB_SUB    = 9'b001011110;
  localparam logic [8:0] V_WB_ADDI   = 9'b001001010;
  localparam logic [8:0] V_WB_SUBI   = 9'b001001110;
  localparam logic [8:0] V_WB_LOAD   = 9'b001000010;
  localparam logic [8:0] V_HALT      = 9'b000000001;

  typedef struct {
    logic [12:0] exp;
    logic        rstn;
    logic        st;
    logic        sp;
    logic [6:0]  op;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [6:0]    opcode;
  logic          pc_we, ir_we, rf_we, dmem_we;
  logic          alu_b_sel, wb_sel, alu_sub, busy, illegal;
  logic [CW-1:0] retired;
  logic [12:0]   obs;

  entry_t sb[$];
  int     retCount   = 0;
  int     checkCount = 0;
  int     errCount   = 0;

  control_unit #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .opcode    (opcode),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .rf_we     (rf_we),
    .dmem_we   (dmem_we),
    .alu_b_sel (alu_b_sel),
    .wb_sel    (wb_sel),
    .alu_sub   (alu_sub),
    .busy      (busy),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  assign obs = {pc_we, ir_we, rf_we, dmem_we, alu_b_sel, wb_sel, alu_sub,
                busy, illegal, retired};

  function automatic logic [CW-1:0] retExp();
`ifdef CU_INSTR_COUNT_EN
    return CW'(retCount % (1 << CW));
`else
    return '0;
`endif
  endfunction

  task automatic pushE(input logic [8:0] ctl, input logic rstn, input logic st,
                       input logic sp, input logic [6:0] op);
    entry_t e;
    e.exp  = {ctl, retExp()};
    e.rstn = rstn;
    e.st   = st;
    e.sp   = sp;
    e.op   = op;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    entry_t e;
    int step = 0;
    pushE(V_IDLE, 1'b0, 1'b1, 1'b0, OP_ADD);
    pushE(V_IDLE, 1'b1, 1'b0, 1'b0, OP_ADD);
    pushE(V_IDLE, 1'b1, 1'b0, 1'b0, OP_ADD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL reset step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  // Seventeen ADDs with no pause; the 4-bit counter wraps past 15.
  task automatic test_back_to_back();
    entry_t e;
    int step = 0;
    pushE(V_IDLE, 1'b1, 1'b1, 1'b0, OP_ADD);
    for (int i = 0; i < 17; i++) begin
      pushE(V_FETCH,    1'b1, 1'b0, i == 16, OP_ADD);
      pushE(V_DECODE,   1'b1, 1'b0, i == 16, OP_ADD);
      pushE(V_EXEC_ADD, 1'b1, 1'b0, i == 16, OP_ADD);
      pushE(V_WB_ADD,   1'b1, 1'b0, i == 16, OP_ADD);
      retCount++;
    end
    pushE(V_IDLE, 1'b1, 1'b0, 1'b0, OP_ADD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL back_to_back step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  task automatic test_alu_ops();
    entry_t e;
    int step = 0;
    logic [6:0] ops  [3] = '{OP_ADD, OP_SUB, OP_ADDI};
    logic [8:0] exs  [3] = '{V_EXEC_ADD, V_EXEC_SUB, V_EXEC_ADDI};
    logic [8:0] wbs  [3] = '{V_WB_ADD, V_WB_SUB, V_WB_ADDI};
    for (int i = 0; i < 3; i++) begin
      pushE(V_IDLE,   1'b1, 1'b1, 1'b0, ops[i]);
      pushE(V_FETCH,  1'b1, 1'b0, 1'b1, ops[i]);
      pushE(V_DECODE, 1'b1, 1'b0, 1'b1, ops[i]);
      pushE(exs[i],   1'b1, 1'b0, 1'b1, ops[i]);
      pushE(wbs[i],   1'b1, 1'b0, 1'b1, ops[i]);
      retCount++;
    end
    pushE(V_IDLE, 1'b1, 1'b0, 1'b0, OP_ADD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL alu_ops step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  task automatic test_load();
    entry_t e;
    int step = 0;
    pushE(V_IDLE,     1'b1, 1'b1, 1'b0, OP_LOAD);
    pushE(V_FETCH,    1'b1, 1'b0, 1'b1, OP_LOAD);
    pushE(V_DECODE,   1'b1, 1'b0, 1'b1, OP_LOAD);
    pushE(V_EXEC_MEM, 1'b1, 1'b0, 1'b1, OP_LOAD);
    pushE(V_MEM_LOAD, 1'b1, 1'b0, 1'b1, OP_LOAD);
    pushE(V_WB_LOAD,  1'b1, 1'b0, 1'b1, OP_LOAD);
    retCount++;
    pushE(V_IDLE,     1'b1, 1'b0, 1'b0, OP_LOAD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL load step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  // STORE with stop low runs straight into the next FETCH (an ADD).
  task automatic test_store();
    entry_t e;
    int step = 0;
    pushE(V_IDLE,      1'b1, 1'b1, 1'b0, OP_STORE);
    pushE(V_FETCH,     1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_DECODE,    1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_EXEC_MEM,  1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_MEM_STORE, 1'b1, 1'b0, 1'b0, OP_STORE);
    retCount++;
    pushE(V_FETCH,     1'b1, 1'b0, 1'b1, OP_ADD);
    pushE(V_DECODE,    1'b1, 1'b0, 1'b1, OP_ADD);
    pushE(V_EXEC_ADD,  1'b1, 1'b0, 1'b1, OP_ADD);
    pushE(V_WB_ADD,    1'b1, 1'b0, 1'b1, OP_ADD);
    retCount++;
    pushE(V_IDLE,      1'b1, 1'b0, 1'b0, OP_ADD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL store step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  // start+stop together in IDLE stays idle; stop raised in EXEC of SUBI.
  task automatic test_stop_subi();
    entry_t e;
    int step = 0;
    pushE(V_IDLE,      1'b1, 1'b1, 1'b1, OP_SUBI);
    pushE(V_IDLE,      1'b1, 1'b1, 1'b0, OP_SUBI);
    pushE(V_FETCH,     1'b1, 1'b0, 1'b0, OP_SUBI);
    pushE(V_DECODE,    1'b1, 1'b0, 1'b0, OP_SUBI);
    pushE(V_EXEC_SUBI, 1'b1, 1'b0, 1'b1, OP_SUBI);
    pushE(V_WB_SUBI,   1'b1, 1'b0, 1'b1, OP_SUBI);
    retCount++;
    pushE(V_IDLE,      1'b1, 1'b0, 1'b0, OP_SUBI);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL stop_subi step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  task automatic test_halt();
    entry_t e;
    int step = 0;
    pushE(V_IDLE,     1'b1, 1'b1, 1'b0, OP_BAD);
    pushE(V_FETCH,    1'b1, 1'b0, 1'b0, OP_BAD);
    pushE(V_DECODE,   1'b1, 1'b0, 1'b0, OP_BAD);
    pushE(V_EXEC_BAD, 1'b1, 1'b0, 1'b0, OP_BAD);
    pushE(V_HALT,     1'b1, 1'b1, 1'b0, OP_ADD);
    pushE(V_HALT,     1'b1, 1'b0, 1'b0, OP_ADD);
    pushE(V_HALT,     1'b0, 1'b0, 1'b0, OP_ADD);
    retCount = 0;
    pushE(V_IDLE,     1'b1, 1'b0, 1'b0, OP_ADD);
    pushE(V_IDLE,     1'b1, 1'b0, 1'b0, OP_ADD);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL halt step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  // Builds up a nonzero count, then resets during MEM of a STORE.
  task automatic test_reset_mid_store();
    entry_t e;
    int step = 0;
    pushE(V_IDLE,      1'b1, 1'b1, 1'b0, OP_ADDI);
    pushE(V_FETCH,     1'b1, 1'b0, 1'b0, OP_ADDI);
    pushE(V_DECODE,    1'b1, 1'b0, 1'b0, OP_ADDI);
    pushE(V_EXEC_ADDI, 1'b1, 1'b0, 1'b0, OP_ADDI);
    pushE(V_WB_ADDI,   1'b1, 1'b0, 1'b0, OP_STORE);
    retCount++;
    pushE(V_FETCH,     1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_DECODE,    1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_EXEC_MEM,  1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_MEM_STORE, 1'b0, 1'b0, 1'b0, OP_STORE);
    retCount = 0;
    pushE(V_IDLE,      1'b1, 1'b0, 1'b0, OP_STORE);
    pushE(V_IDLE,      1'b1, 1'b0, 1'b0, OP_STORE);
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checkCount++;
      if (obs !== e.exp) begin
        errCount++;
        $display("[TB] FAIL reset_mid_store step %0d: observed %b expected %b", step, obs, e.exp);
      end
      rst_n = e.rstn; start = e.st; stop = e.sp; opcode = e.op;
      step++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    opcode = '0;
    test_reset();
    test_back_to_back();
    test_alu_ops();
    test_load();
    test_store();
    test_stop_subi();
    test_halt();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
